mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle MIPS main controller: a Moore state machine that sequences the shared datapath (single memory, ALU, register file, PC) through fetch, decode, execute, memory and writeback steps for each instruction. It decodes the 6-bit opcode held in the instruction register and drives all datapath enables and mux selects. It sends the 2-bit `aluop` to `aludec`, which produces `alucontrol`. It also produces the gated PC enable from the ALU `zero` flag.

## Interface
Parameters:
- None. The opcode and state encodings are fixed.

Ports:
- `clk`  input  1  system clock; all state changes occur on the rising edge.
- `reset`  input  1  synchronous, active-high; forces state to FETCH.
- `op`  input  6  opcode from the instruction register (`instr[31:26]`); sampled in DECODE and the execute states.
- `zero`  input  1  ALU zero flag; used only for `pcen`.
- `state`  output  4  current state encoding, for debug and verification.
- `pcen`  output  1  PC register enable.
- `memwrite`  output  1  memory write strobe.
- `irwrite`  output  1  instruction register load.
- `regwrite`  output  1  register-file write enable.
- `alusrca`  output  1  ALU A select: 0 = PC, 1 = register A.
- `iord`  output  1  memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg`  output  1  writeback data select: 0 = ALUOut, 1 = data register.
- `regdst`  output  1  destination register select: 0 = rt, 1 = rd.
- `alusrcb`  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcsrc`  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`  output  2  to `aludec`: 00 = add, 01 = subtract, 10 = decode the funct field.

## Operation
State encoding (4-bit):
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
- RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Codes 12–15 are unused.

Opcodes:
- LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.

Transitions:
- FETCH -> DECODE.
- DECODE, by `op`:
  - LW or SW -> MEMADR.
  - RTYPE -> RTYPEEX.
  - BEQ -> BEQEX.
  - ADDI -> ADDIEX.
  - J -> JEX.
  - Any other opcode -> FETCH (executed as a nop; no architectural write).
- MEMADR: LW -> MEMRD; SW -> MEMWR; anything else -> FETCH.
- MEMRD -> MEMWB.
- RTYPEEX -> RTYPEWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX all -> FETCH.
- Unused codes 12–15 -> FETCH on the next edge. All outputs are 0 while in them.

Outputs are a pure function of `state`. Any signal not listed for a state is 0.
- FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00, `irwrite`=1, `pcwrite`=1.
- DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00. This computes the branch target into ALUOut.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00.
- MEMRD: `iord`=1.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1.
- MEMWR: `iord`=1, `memwrite`=1.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1.
- BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00.
- ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1.
- JEX: `pcsrc`=10, `pcwrite`=1.

`pcwrite` and `branch` are internal only. `pcen` = `pcwrite` | (`branch` & `zero`). This is the only combinational dependence on an input.

## Timing
- State register updates on the rising edge of `clk`. `reset` has priority over every transition.
- While `reset` is high at an edge, `state` becomes FETCH (0). FETCH outputs therefore appear the cycle after reset is sampled, including during reset hold.
- Reset asserted mid-instruction abandons that instruction. No further `regwrite` or `memwrite` pulses are issued; the datapath owns PC/register reset.
- Latency in cycles, FETCH to the next FETCH:
  - LW 5.
  - SW, RTYPE and ADDI 4.
  - BEQ and J 3.
  - Unknown opcode 2.
- `regwrite` and `memwrite` are exactly one cycle wide per instruction.
- `irwrite` is high only in FETCH.
- `op` must be stable from DECODE through the end of the instruction; the IR is not written outside FETCH.
- `pcen` follows `zero` within the same cycle in BEQEX. It has no registered delay.

## Test plan
- Reset then `op`=RTYPE: state sequence 0,1,6,7,0. In state 6, `aluop`=10 and `alusrca`=1. In state 7, `regwrite`=1 and `regdst`=1.
- `op`=LW: sequence 0,1,2,3,4,0. In state 3, `iord`=1. In state 4, `memtoreg`=1 and `regwrite`=1. `memwrite` stays 0 throughout.
- `op`=SW: sequence 0,1,2,5,0. In state 5, `memwrite`=1 for exactly one cycle and `iord`=1.
- `op`=BEQ in BEQEX, with `pcsrc`=01 and `aluop`=01 checked:
  - `zero`=1 -> `pcen`=1.
  - `zero`=0 -> `pcen`=0.
  - Then `op`=J: sequence 0,1,11,0 with `pcsrc`=10 and `pcen`=1 in state 11.
- `op`=6'b111111 (undefined): sequence 0,1,0. No `regwrite` or `memwrite` pulse.
- Reset asserted while in state 3 (LW): next state 0, no `regwrite` pulse. After reset is released, the next instruction is fetched normally.

Source files
------------

// File: rtl/mainfsm.sv
`default_nettype none
// ============================================================================
// Module   : mainfsm
// Brief    : Multicycle MIPS main controller; Moore FSM sequencing the shared
//            datapath and producing the gated PC enable.
// Revision : 1.0
// ============================================================================
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [3:0] state,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop
);

    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb = 2'b11;
                case (op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_RTYPEEX;
                    C_OP_BEQ:         w_next = S_BEQEX;
                    C_OP_ADDI:        w_next = S_ADDIEX;
                    C_OP_J:           w_next = S_JEX;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == C_OP_LW) begin
                    w_next = S_MEMRD;
                end else if (op == C_OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_next  = S_RTYPEWB;
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                w_next  = S_ADDIWB;
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign state = r_state;
    assign pcen  = w_pcwrite | (w_branch & zero);

endmodule
`default_nettype wire

// File: tb/tb_mainfsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mainfsm
// Brief    : Self-checking bench for mainfsm: path-queue reference model plus
//            directed instruction sequences with literal expectations.
// Revision : 1.0
// ============================================================================
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic [3:0] state;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc, aluop;

    int total = 0;
    int bad   = 0;

    mainfsm dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .state    (state),
        .pcen     (pcen),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction's remaining states are queued when it is decoded.
    logic [3:0] m_state;
    logic [3:0] m_q[$];
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 4'd0;
            m_q.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_state == 4'd0) begin
                m_state = 4'd1;
            end else if (m_state == 4'd1) begin
                case (op)
                    6'b100011: begin m_state = 4'd2;  m_q = '{4'd3, 4'd4}; end
                    6'b101011: begin m_state = 4'd2;  m_q = '{4'd5};       end
                    6'b000000: begin m_state = 4'd6;  m_q = '{4'd7};       end
                    6'b000100: begin m_state = 4'd8;  m_q.delete();        end
                    6'b001000: begin m_state = 4'd9;  m_q = '{4'd10};      end
                    6'b000010: begin m_state = 4'd11; m_q.delete();        end
                    default:   begin m_state = 4'd0;  m_q.delete();        end
                endcase
            end else if (m_q.size() > 0) begin
                m_state = m_q.pop_front();
            end else begin
                m_state = 4'd0;
            end
        end
    end

    // {memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, aluop}
    function automatic logic [12:0] exp_ctl(input logic [3:0] s);
        logic mw, ir, rw, sa, io, mr, rd;
        logic [1:0] sb, ps, ao;
        {mw, ir, rw, sa, io, mr, rd} = 7'b0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            4'd0:  begin ir = 1'b1; sb = 2'b01; end
            4'd1:  begin sb = 2'b11; end
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin io = 1'b1; end
            4'd4:  begin mr = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 1'b1; ao = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; end
            4'd11: begin ps = 2'b10; end
            default: ;
        endcase
        return {mw, ir, rw, sa, io, mr, rd, sb, ps, ao};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", state, m_state);
            chk("ctl", {memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                        alusrcb, pcsrc, aluop}, exp_ctl(m_state));
            chk("pcen", pcen, (m_state == 4'd0 || m_state == 4'd11 || (m_state == 4'd8 && zero)));
        end
    end

    // Per-instruction capture for literal checks.
    logic [31:0] seq;
    int          lat, rw_cnt, mw_cnt;
    logic        snap_pcen  [16];
    logic [1:0]  snap_pcsrc [16];
    logic [1:0]  snap_aluop [16];
    logic        snap_sa    [16];
    logic        snap_iord  [16];
    logic        snap_rd    [16];
    logic        snap_mr    [16];

    // Starts at a falling edge in FETCH, ends at the falling edge of the next FETCH.
    task automatic do_instr(input string nm, input logic [5:0] o, input logic z,
                            input logic [31:0] exp_seq, input int exp_lat,
                            input int exp_rw, input int exp_mw);
        op = o;
        zero = z;
        seq = 32'h0;
        lat = 0;
        rw_cnt = 0;
        mw_cnt = 0;
        do begin
            seq = (seq << 4) | {28'h0, state};
            lat++;
            rw_cnt += int'(regwrite);
            mw_cnt += int'(memwrite);
            snap_pcen[state]  = pcen;
            snap_pcsrc[state] = pcsrc;
            snap_aluop[state] = aluop;
            snap_sa[state]    = alusrca;
            snap_iord[state]  = iord;
            snap_rd[state]    = regdst;
            snap_mr[state]    = memtoreg;
            @(posedge clk);
            @(negedge clk);
        end while (state != 4'd0 && lat < 12);
        chk({nm, "_seq"}, seq, exp_seq);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_regwrite_pulses"}, rw_cnt, exp_rw);
        chk({nm, "_memwrite_pulses"}, mw_cnt, exp_mw);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", state, 4'd0);
        chk("reset_irwrite", irwrite, 1'b1);
        chk("reset_pcen", pcen, 1'b1);
        reset = 1'b0;

        do_instr("rtype", 6'b000000, 1'b0, 32'h0167, 4, 1, 0);
        chk("rtype_ex_aluop", snap_aluop[6], 2'b10);
        chk("rtype_ex_alusrca", snap_sa[6], 1'b1);
        chk("rtype_wb_regdst", snap_rd[7], 1'b1);

        do_instr("lw", 6'b100011, 1'b0, 32'h01234, 5, 1, 0);
        chk("lw_rd_iord", snap_iord[3], 1'b1);
        chk("lw_wb_memtoreg", snap_mr[4], 1'b1);

        do_instr("sw", 6'b101011, 1'b0, 32'h0125, 4, 0, 1);
        chk("sw_wr_iord", snap_iord[5], 1'b1);

        do_instr("beq_taken", 6'b000100, 1'b1, 32'h018, 3, 0, 0);
        chk("beq_taken_pcen", snap_pcen[8], 1'b1);
        chk("beq_pcsrc", snap_pcsrc[8], 2'b01);
        chk("beq_aluop", snap_aluop[8], 2'b01);

        do_instr("beq_nottaken", 6'b000100, 1'b0, 32'h018, 3, 0, 0);
        chk("beq_nottaken_pcen", snap_pcen[8], 1'b0);

        do_instr("j", 6'b000010, 1'b0, 32'h01B, 3, 0, 0);
        chk("j_pcsrc", snap_pcsrc[11], 2'b10);
        chk("j_pcen", snap_pcen[11], 1'b1);

        do_instr("undef", 6'b111111, 1'b0, 32'h01, 2, 0, 0);

        do_instr("addi", 6'b001000, 1'b0, 32'h019A, 4, 1, 0);

        // Abort an LW in MEMRD with reset.
        op = 6'b100011;
        for (int i = 0; i < 8 && state != 4'd3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_reached_memrd", state, 4'd3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_state", state, 4'd0);
        chk("abort_regwrite", regwrite, 1'b0);
        reset = 1'b0;

        do_instr("after_reset", 6'b001000, 1'b0, 32'h019A, 4, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
